// File: rtl/branch_pkg.sv
// Shared branch definitions: RV32 conditional-branch funct3 encodings,
// branch-condition evaluation and the saturating-counter step used by the BHT.
package branch_pkg;

  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } br_f3_e;

  // Operand width seen by br_taken; callers sign-extend narrower operands.
  // Sign extension preserves both signed and unsigned ordering, so one
  // fixed-width comparator serves every XLEN up to this width.
  localparam int unsigned BR_OPW   = 64;
  // Widest counter the saturating helper handles.
  localparam int unsigned CTR_MAXW = 8;

  // 010 and 011 are not branches; everything else is.
  function automatic logic br_legal(input logic [2:0] f3);
    return f3[2] | ~f3[1];
  endfunction

  function automatic logic br_taken(input logic [2:0] f3,
                                    input logic [BR_OPW-1:0] a,
                                    input logic [BR_OPW-1:0] b);
    logic t;
    t = 1'b0;
    case (f3)
      F3_BEQ:  t = (a == b);
      F3_BNE:  t = (a != b);
      F3_BLT:  t = ($signed(a) <  $signed(b));
      F3_BGE:  t = ($signed(a) >= $signed(b));
      F3_BLTU: t = (a <  b);
      F3_BGEU: t = (a >= b);
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  // One step of a saturating up/down counter bounded by [0, cmax].
  function automatic logic [CTR_MAXW-1:0] ctr_sat(input logic [CTR_MAXW-1:0] c,
                                                  input logic                up,
                                                  input logic [CTR_MAXW-1:0] cmax);
    if (up) return (c == cmax) ? c : c + 1'b1;
    else    return (c == '0)   ? c : c - 1'b1;
  endfunction

endpackage

// File: rtl/bht_table.sv
// Direct-mapped table of saturating counters: combinational read of the
// counter MSB, single write port that steps one counter toward the outcome.
module bht_table
  import branch_pkg::*;
#(
  parameter int unsigned ENTRIES  = 16,
  parameter int unsigned CTR_BITS = 2,
  parameter int unsigned CTR_INIT = 1,
  localparam int unsigned IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic             rd_taken_o,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic             wr_taken_i
);

  localparam logic [CTR_BITS-1:0] CMAX = '1;
  localparam logic [CTR_BITS-1:0] INIT = CTR_BITS'(CTR_INIT);

  logic [CTR_BITS-1:0] r_tab [ENTRIES];

  // Read returns the stored value; a same-cycle write is not bypassed.
  assign rd_taken_o = r_tab[rd_idx_i][CTR_BITS-1];

  // Reset all counters, otherwise step the addressed counter on a resolve.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < ENTRIES; i++) r_tab[i] <= INIT;
    end else if (wr_en_i) begin
      r_tab[wr_idx_i] <= CTR_BITS'(ctr_sat(CTR_MAXW'(r_tab[wr_idx_i]), wr_taken_i,
                                           CTR_MAXW'(CMAX)));
    end
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch unit: BHT-based prediction in ID, branch resolution and mispredict
// flush/redirect in EX. Define BRANCH_STATS_EN to add saturating branch and
// mispredict counters.
module branch_predict_unit
  import branch_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned BHT_ENTRIES = 16,
  parameter int unsigned CTR_BITS    = 2,
  parameter int unsigned CTR_INIT    = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            id_branch_i,
  input  logic [XLEN-1:0] id_pc_i,
  input  logic [XLEN-1:0] id_imm_i,
  output logic            id_pred_taken_o,
  output logic [XLEN-1:0] id_target_o,
  input  logic            ex_valid_i,
  input  logic            ex_branch_i,
  input  logic [XLEN-1:0] ex_pc_i,
  input  logic [2:0]      ex_funct3_i,
  input  logic [XLEN-1:0] ex_rs1_i,
  input  logic [XLEN-1:0] ex_rs2_i,
  input  logic            ex_pred_taken_i,
  input  logic [XLEN-1:0] ex_target_i,
  output logic            flush_o,
  output logic [XLEN-1:0] redirect_pc_o
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]     branch_cnt_o,
  output logic [31:0]     mispredict_cnt_o
`endif
);

  localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);

  logic                     w_rd_taken;
  logic                     w_resolve;
  logic                     w_legal;
  logic                     w_taken;
  logic                     w_mispredict;
  logic signed [BR_OPW-1:0] w_rs1_x;
  logic signed [BR_OPW-1:0] w_rs2_x;

  bht_table #(
    .ENTRIES  (BHT_ENTRIES),
    .CTR_BITS (CTR_BITS),
    .CTR_INIT (CTR_INIT)
  ) u_bht (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .rd_idx_i   (id_pc_i[IDX_W+1:2]),
    .rd_taken_o (w_rd_taken),
    .wr_en_i    (w_resolve & w_legal),
    .wr_idx_i   (ex_pc_i[IDX_W+1:2]),
    .wr_taken_i (w_taken)
  );

  assign id_pred_taken_o = id_branch_i & w_rd_taken;
  assign id_target_o     = id_pc_i + (id_imm_i << 1);

  assign w_rs1_x      = BR_OPW'($signed(ex_rs1_i));
  assign w_rs2_x      = BR_OPW'($signed(ex_rs2_i));
  assign w_resolve    = ex_valid_i & ex_branch_i;
  assign w_legal      = br_legal(ex_funct3_i);
  assign w_taken      = br_taken(ex_funct3_i, w_rs1_x, w_rs2_x);
  assign w_mispredict = w_resolve & (w_taken != ex_pred_taken_i);
  assign flush_o      = w_mispredict;

  // Corrected PC on a mispredict, zero otherwise.
  always_comb begin
    redirect_pc_o = '0;
    if (w_mispredict) redirect_pc_o = w_taken ? ex_target_i : ex_pc_i + XLEN'(4);
  end

`ifdef BRANCH_STATS_EN
  logic [31:0] r_branch_cnt;
  logic [31:0] r_mispredict_cnt;

  // Saturating counts of resolved branches and of mispredicts.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_branch_cnt     <= '0;
      r_mispredict_cnt <= '0;
    end else begin
      if (w_resolve && r_branch_cnt != '1)        r_branch_cnt     <= r_branch_cnt + 1'b1;
      if (w_mispredict && r_mispredict_cnt != '1) r_mispredict_cnt <= r_mispredict_cnt + 1'b1;
    end
  end

  assign branch_cnt_o     = r_branch_cnt;
  assign mispredict_cnt_o = r_mispredict_cnt;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Bench for branch_predict_unit: a table-of-integers model checked every
// cycle, plus hand-computed literal expectations along a directed sequence.
module tb_branch_predict_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_branch;
  logic [31:0] id_pc, id_imm;
  logic        id_pred_taken;
  logic [31:0] id_target;
  logic        ex_valid, ex_branch;
  logic [31:0] ex_pc;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_rs1, ex_rs2;
  logic        ex_pred_taken;
  logic [31:0] ex_target;
  logic        flush;
  logic [31:0] redirect_pc;
`ifdef BRANCH_STATS_EN
  logic [31:0] branch_cnt, mispredict_cnt;
`endif

  branch_predict_unit #(
    .XLEN        (32),
    .BHT_ENTRIES (16),
    .CTR_BITS    (2),
    .CTR_INIT    (1)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .id_branch_i     (id_branch),
    .id_pc_i         (id_pc),
    .id_imm_i        (id_imm),
    .id_pred_taken_o (id_pred_taken),
    .id_target_o     (id_target),
    .ex_valid_i      (ex_valid),
    .ex_branch_i     (ex_branch),
    .ex_pc_i         (ex_pc),
    .ex_funct3_i     (ex_funct3),
    .ex_rs1_i        (ex_rs1),
    .ex_rs2_i        (ex_rs2),
    .ex_pred_taken_i (ex_pred_taken),
    .ex_target_i     (ex_target),
    .flush_o         (flush),
    .redirect_pc_o   (redirect_pc)
`ifdef BRANCH_STATS_EN
    ,
    .branch_cnt_o     (branch_cnt),
    .mispredict_cnt_o (mispredict_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int      m_ctr [16];
  bit      m_ok = 0;
  longint  m_bcnt, m_mcnt;

  function automatic bit m_taken(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    case (f)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) <  $signed(b);
      3'd5: return $signed(a) >= $signed(b);
      3'd6: return a <  b;
      3'd7: return a >= b;
      default: return 0;
    endcase
  endfunction

  function automatic int m_idx(input logic [31:0] pc);
    return int'((pc / 4) % 16);
  endfunction

  function automatic bit m_flush();
    return ex_valid && ex_branch && (m_taken(ex_funct3, ex_rs1, ex_rs2) != ex_pred_taken);
  endfunction

  // Model state advances on the same edge as the DUT.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) m_ctr[i] = 1;
      m_bcnt = 0;
      m_mcnt = 0;
      m_ok   = 1;
    end else if (m_ok) begin
      if (ex_valid && ex_branch) begin
        if (m_bcnt < 64'hFFFF_FFFF) m_bcnt++;
        if (m_flush() && m_mcnt < 64'hFFFF_FFFF) m_mcnt++;
        if (ex_funct3 != 3'd2 && ex_funct3 != 3'd3) begin
          if (m_taken(ex_funct3, ex_rs1, ex_rs2)) m_ctr[m_idx(ex_pc)] = (m_ctr[m_idx(ex_pc)] < 3) ? m_ctr[m_idx(ex_pc)] + 1 : 3;
          else                                    m_ctr[m_idx(ex_pc)] = (m_ctr[m_idx(ex_pc)] > 0) ? m_ctr[m_idx(ex_pc)] - 1 : 0;
        end
      end
    end
  end

  // Every-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    if (m_ok) begin
      logic [31:0] exp_redir;
      exp_redir = 32'h0;
      if (m_flush()) exp_redir = m_taken(ex_funct3, ex_rs1, ex_rs2) ? ex_target : ex_pc + 32'd4;
      check("cyc_pred",   {31'b0, id_pred_taken}, {31'b0, (id_branch && m_ctr[m_idx(id_pc)] >= 2)});
      check("cyc_target", id_target, id_pc + id_imm * 2);
      check("cyc_flush",  {31'b0, flush}, {31'b0, m_flush()});
      check("cyc_redir",  redirect_pc, exp_redir);
`ifdef BRANCH_STATS_EN
      check("cyc_bcnt",   branch_cnt,     m_bcnt[31:0]);
      check("cyc_mcnt",   mispredict_cnt, m_mcnt[31:0]);
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic id_set(input logic br, input logic [31:0] pc, input logic [31:0] imm);
    id_branch = br; id_pc = pc; id_imm = imm;
  endtask

  task automatic ex_set(input logic v, input logic [31:0] pc, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic pr, input logic [31:0] tg);
    ex_valid = v; ex_branch = 1'b1; ex_pc = pc; ex_funct3 = f3;
    ex_rs1 = a; ex_rs2 = b; ex_pred_taken = pr; ex_target = tg;
  endtask

  task automatic ex_clr();
    ex_valid = 0; ex_branch = 0; ex_pc = 0; ex_funct3 = 0;
    ex_rs1 = 0; ex_rs2 = 0; ex_pred_taken = 0; ex_target = 0;
  endtask

  logic [2:0]  sw_f3 [9] = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b101, 3'b110, 3'b111, 3'b100, 3'b011};
  logic [31:0] sw_a  [9] = '{32'd3, 32'd3, 32'h8000_0000, 32'h8000_0000, 32'd5, 32'h8000_0000, 32'd0, 32'd1, 32'd1};
  logic [31:0] sw_b  [9] = '{32'd4, 32'd3, 32'd1, 32'd1, 32'd5, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2};

  initial begin
    rst = 1;
    id_set(0, 0, 0);
    ex_clr();
    tick(); tick();
    rst = 0;
    #1;
    check("rst_flush", {31'b0, flush}, 32'd0);
    check("rst_pred",  {31'b0, id_pred_taken}, 32'd0);
    check("rst_redir", redirect_pc, 32'd0);

    // Prediction after reset and target formation.
    id_set(1, 32'h100, 32'h8);
    #1;
    check("t1_pred",   {31'b0, id_pred_taken}, 32'd0);
    check("t1_target", id_target, 32'h110);
    tick();

    // beq taken, predicted not-taken.
    ex_set(1, 32'h100, 3'b000, 32'd5, 32'd5, 0, 32'h110);
    #1;
    check("t2_flush", {31'b0, flush}, 32'd1);
    check("t2_redir", redirect_pc, 32'h110);
    tick();
    ex_clr();
    #1;
    check("t2_pred_after", {31'b0, id_pred_taken}, 32'd1);
    tick();

    // bltu vs blt on the same operands.
    ex_set(1, 32'h40, 3'b110, 32'hFFFF_FFFF, 32'd1, 1, 32'h80);
    #1;
    check("t3_bltu_flush", {31'b0, flush}, 32'd1);
    check("t3_bltu_redir", redirect_pc, 32'h44);
    tick();
    ex_set(1, 32'h40, 3'b100, 32'hFFFF_FFFF, 32'd1, 1, 32'h80);
    #1;
    check("t3_blt_flush", {31'b0, flush}, 32'd0);
    tick();

    // Saturation at pc 0x8: four taken, then not-taken steps down.
    id_set(1, 32'h8, 32'h4);
    for (int i = 0; i < 4; i++) begin
      ex_set(1, 32'h8, 3'b000, 32'd0, 32'd0, 1, 32'h10);
      tick();
    end
    ex_set(1, 32'h8, 3'b001, 32'd0, 32'd0, 1, 32'h10);
    #1;
    check("t4_nt_redir", redirect_pc, 32'hC);
    tick();
    ex_clr();
    #1;
    check("t4_pred_sat_dec", {31'b0, id_pred_taken}, 32'd1);
    tick();
    ex_set(1, 32'h8, 3'b001, 32'd0, 32'd0, 1, 32'h10);
    tick();
    ex_clr();
    #1;
    check("t4_pred_weak", {31'b0, id_pred_taken}, 32'd0);
    tick();

    // Same-cycle read/update of index 0: no bypass.
    ex_set(1, 32'h0, 3'b001, 32'd9, 32'd9, 0, 32'h4);
    tick();
    id_set(1, 32'h40, 32'h2);
    ex_set(1, 32'h0, 3'b000, 32'd7, 32'd7, 0, 32'h4);
    #1;
    check("t5_pred_same", {31'b0, id_pred_taken}, 32'd0);
    check("t5_redir",     redirect_pc, 32'h4);
    tick();
    ex_clr();
    #1;
    check("t5_pred_next", {31'b0, id_pred_taken}, 32'd1);
    tick();

    // Bubble in EX: no flush, no update.
    id_set(1, 32'hC, 32'h2);
    ex_set(0, 32'hC, 3'b000, 32'd1, 32'd1, 0, 32'h20);
    #1;
    check("t6_bubble_flush", {31'b0, flush}, 32'd0);
    tick();
    ex_clr();
    #1;
    check("t6_bubble_pred", {31'b0, id_pred_taken}, 32'd0);
    tick();
    // Raise idx3 to 2, then an illegal funct3 must not touch it.
    ex_set(1, 32'hC, 3'b000, 32'd1, 32'd1, 1, 32'h20);
    tick();
    ex_set(1, 32'hC, 3'b010, 32'd1, 32'd1, 1, 32'h20);
    #1;
    check("t6_illegal_flush", {31'b0, flush}, 32'd1);
    check("t6_illegal_redir", redirect_pc, 32'h10);
    tick();
    ex_clr();
    #1;
    check("t6_illegal_pred", {31'b0, id_pred_taken}, 32'd1);
    tick();

    // Sweep of all branch types at pc 0x20.
    id_set(1, 32'h20, 32'h20);
    for (int i = 0; i < 9; i++) begin
      ex_set(1, 32'h20, sw_f3[i], sw_a[i], sw_b[i], 0, 32'h60);
      tick();
    end

    // Wrap-around of PC+4 and target.
    ex_set(1, 32'hFFFF_FFFC, 3'b001, 32'd1, 32'd1, 1, 32'h8);
    id_set(1, 32'hFFFF_FFF0, 32'h10);
    #1;
    check("wrap_redir",  redirect_pc, 32'h0);
    check("wrap_target", id_target, 32'h10);
    tick();
    id_set(1, 32'h100, 32'hFFFF_FFFC);
    ex_clr();
    #1;
    check("neg_target", id_target, 32'hF8);
    tick();

    // Reset wins over a same-cycle taken update.
    id_set(1, 32'h8, 32'h0);
    ex_set(1, 32'h8, 3'b000, 32'd2, 32'd2, 0, 32'h30);
    rst = 1;
    tick();
    rst = 0;
    ex_clr();
    #1;
    check("rst_pred_idx2", {31'b0, id_pred_taken}, 32'd0);
`ifdef BRANCH_STATS_EN
    check("rst_bcnt", branch_cnt, 32'd0);
    check("rst_mcnt", mispredict_cnt, 32'd0);
`endif
    id_set(1, 32'h100, 32'h0);
    #1;
    check("rst_pred_idx0", {31'b0, id_pred_taken}, 32'd0);
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
